// File: rtl/branch_queue.sv
// branch_queue: circular queue of in-flight branches; checks predictions on resolve, raises a registered redirect, supports commit and squash.
//   clk/rst                  : clock, synchronous active-high reset
//   push_*                   : decode allocates one entry at the tail (push_bqid_o = slot), push_ready_o = not full
//   resolve_*                : branch unit outcome for an entry; mispredict_* is the registered redirect one cycle later
//   commit_valid_i           : retire head entry; head_valid_o / head_resolved_o report head status
//   squash_*                 : keep=1 drops everything younger than squash_bqid_i, keep=0 drops everything
module branch_queue #(
  parameter int DEPTH = 8,
  parameter int ID_W = 8,
  localparam int BQID_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [63:0]       push_pc_i,
  input  logic [ID_W-1:0]   push_id_i,
  input  logic              push_bp_taken_i,
  input  logic [63:0]       push_bp_pcnext_i,
  output logic [BQID_W-1:0] push_bqid_o,
  input  logic              resolve_valid_i,
  input  logic [BQID_W-1:0] resolve_bqid_i,
  input  logic              resolve_taken_i,
  input  logic [63:0]       resolve_target_i,
  output logic              mispredict_valid_o,
  output logic [ID_W-1:0]   mispredict_id_o,
  output logic [BQID_W-1:0] mispredict_bqid_o,
  output logic [63:0]       mispredict_pc_o,
  input  logic              commit_valid_i,
  output logic              head_valid_o,
  output logic              head_resolved_o,
  input  logic              squash_valid_i,
  input  logic              squash_keep_i,
  input  logic [BQID_W-1:0] squash_bqid_i
);
  localparam logic [BQID_W:0] full = (BQID_W+1)'(DEPTH);
  logic [BQID_W-1:0] head, tail, head_next, tail_next, keep_off, res_off;
  logic [BQID_W:0]   count, count_next;
  logic [DEPTH-1:0]  valid, resolved, valid_next, resolved_next, kill;
  logic [63:0]       pc_mem [DEPTH];
  logic [63:0]       pcnext_mem [DEPTH];
  logic [ID_W-1:0]   id_mem [DEPTH];
  logic [DEPTH-1:0]  taken_mem;
  logic              do_commit, do_push, res_killed, mis;
  assign push_ready_o = count != full;
  assign push_bqid_o = tail;
  assign head_valid_o = count != '0;
  assign head_resolved_o = resolved[head] && head_valid_o;
  // Entry ages are measured as distance from head so wrap-around compares correctly.
  // A full queue still takes a push when the head retires in the same cycle.
  always_comb begin
    do_commit = commit_valid_i && count != '0;
    do_push = push_valid_i && !squash_valid_i && (count != full || do_commit);
    head_next = head + BQID_W'(do_commit);
    keep_off = squash_bqid_i - head;
    res_off = resolve_bqid_i - head;
    res_killed = squash_valid_i && (!squash_keep_i || res_off > keep_off);
    mis = resolve_valid_i && valid[resolve_bqid_i] && !res_killed &&
          (resolve_taken_i != taken_mem[resolve_bqid_i] ||
           (resolve_taken_i && resolve_target_i != pcnext_mem[resolve_bqid_i]));
    kill = '0;
    for (int i = 0; i < DEPTH; i++)
      kill[i] = squash_valid_i && (!squash_keep_i || (BQID_W'(i) - head) > keep_off);
    valid_next = valid;
    resolved_next = resolved;
    if (resolve_valid_i && valid[resolve_bqid_i]) resolved_next[resolve_bqid_i] = 1'b1;
    if (do_commit) begin
      valid_next[head] = 1'b0;
      resolved_next[head] = 1'b0;
    end
    valid_next = valid_next & ~kill;
    resolved_next = resolved_next & ~kill;
    if (do_push) begin
      valid_next[tail] = 1'b1;
      resolved_next[tail] = 1'b0;
    end
    tail_next = squash_valid_i ? (squash_keep_i ? squash_bqid_i + BQID_W'(1) : head_next)
                               : tail + BQID_W'(do_push);
    count_next = squash_valid_i ? (squash_keep_i ? {1'b0, keep_off} + (BQID_W+1)'(1) - (BQID_W+1)'(do_commit) : '0)
                                : count + (BQID_W+1)'(do_push) - (BQID_W+1)'(do_commit);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
      resolved <= '0;
      mispredict_valid_o <= 1'b0;
      mispredict_id_o <= '0;
      mispredict_bqid_o <= '0;
      mispredict_pc_o <= '0;
    end else begin
      head <= head_next;
      tail <= tail_next;
      count <= count_next;
      valid <= valid_next;
      resolved <= resolved_next;
      mispredict_valid_o <= mis;
      if (mis) begin
        mispredict_id_o <= id_mem[resolve_bqid_i];
        mispredict_bqid_o <= resolve_bqid_i;
        mispredict_pc_o <= resolve_taken_i ? resolve_target_i : pc_mem[resolve_bqid_i] + 64'd4;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[tail] <= push_pc_i;
      pcnext_mem[tail] <= push_bp_pcnext_i;
      id_mem[tail] <= push_id_i;
      taken_mem[tail] <= push_bp_taken_i;
    end
  end
endmodule

// File: tb/tb_branch_queue.sv
// tb_branch_queue: self-checking bench for branch_queue with a mispredict scoreboard.
module tb_branch_queue;
  localparam int ID_W = 8;
  localparam int BW = 3;
  logic clk = 1'b0;
  logic rst;
  logic push_valid_i, push_ready_o, push_bp_taken_i;
  logic [63:0] push_pc_i, push_bp_pcnext_i, resolve_target_i, mispredict_pc_o;
  logic [ID_W-1:0] push_id_i, mispredict_id_o;
  logic [BW-1:0] push_bqid_o, resolve_bqid_i, mispredict_bqid_o, squash_bqid_i;
  logic resolve_valid_i, resolve_taken_i, mispredict_valid_o;
  logic commit_valid_i, head_valid_o, head_resolved_o;
  logic squash_valid_i, squash_keep_i;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [BW-1:0] bqid;
    logic [63:0] pc;
  } mp_t;
  mp_t sb[$];
  mp_t mon_exp;
  int n_total = 0;
  int n_pass = 0;

  branch_queue #(.DEPTH(8), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_pc_i(push_pc_i),
    .push_id_i(push_id_i), .push_bp_taken_i(push_bp_taken_i), .push_bp_pcnext_i(push_bp_pcnext_i),
    .push_bqid_o(push_bqid_o),
    .resolve_valid_i(resolve_valid_i), .resolve_bqid_i(resolve_bqid_i),
    .resolve_taken_i(resolve_taken_i), .resolve_target_i(resolve_target_i),
    .mispredict_valid_o(mispredict_valid_o), .mispredict_id_o(mispredict_id_o),
    .mispredict_bqid_o(mispredict_bqid_o), .mispredict_pc_o(mispredict_pc_o),
    .commit_valid_i(commit_valid_i), .head_valid_o(head_valid_o), .head_resolved_o(head_resolved_o),
    .squash_valid_i(squash_valid_i), .squash_keep_i(squash_keep_i), .squash_bqid_i(squash_bqid_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mispredict_valid_o === 1'b1) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL mispredict_unexpected: got id %h bqid %0d pc %h, required no mispredict",
                 mispredict_id_o, mispredict_bqid_o, mispredict_pc_o);
      end else begin
        mon_exp = sb.pop_front();
        if ({mispredict_id_o, mispredict_bqid_o, mispredict_pc_o} !== mon_exp)
          $display("FAIL mispredict_payload: got id %h bqid %0d pc %h, required id %h bqid %0d pc %h",
                   mispredict_id_o, mispredict_bqid_o, mispredict_pc_o, mon_exp.id, mon_exp.bqid, mon_exp.pc);
        else n_pass++;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic push(input logic [63:0] pc, input logic [ID_W-1:0] id, input logic t, input logic [63:0] nx);
    push_valid_i = 1'b1;
    push_pc_i = pc;
    push_id_i = id;
    push_bp_taken_i = t;
    push_bp_pcnext_i = nx;
    cycle();
    push_valid_i = 1'b0;
  endtask

  task automatic resolve(input logic [BW-1:0] b, input logic t, input logic [63:0] tgt);
    resolve_valid_i = 1'b1;
    resolve_bqid_i = b;
    resolve_taken_i = t;
    resolve_target_i = tgt;
    cycle();
    resolve_valid_i = 1'b0;
  endtask

  task automatic commit();
    commit_valid_i = 1'b1;
    cycle();
    commit_valid_i = 1'b0;
  endtask

  task automatic squash(input logic keep, input logic [BW-1:0] b);
    squash_valid_i = 1'b1;
    squash_keep_i = keep;
    squash_bqid_i = b;
    cycle();
    squash_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    n_total++; if (push_ready_o !== 1'b1) $display("FAIL reset_ready: got %b required 1", push_ready_o); else n_pass++;
    n_total++; if (push_bqid_o !== 3'd0) $display("FAIL reset_bqid: got %0d required 0", push_bqid_o); else n_pass++;
    n_total++; if (head_valid_o !== 1'b0) $display("FAIL reset_head_valid: got %b required 0", head_valid_o); else n_pass++;
    n_total++; if (head_resolved_o !== 1'b0) $display("FAIL reset_head_resolved: got %b required 0", head_resolved_o); else n_pass++;
    n_total++;
    if ({mispredict_valid_o, mispredict_id_o, mispredict_bqid_o, mispredict_pc_o} !== '0)
      $display("FAIL reset_mispredict: got v %b id %h bqid %0d pc %h required all zero",
               mispredict_valid_o, mispredict_id_o, mispredict_bqid_o, mispredict_pc_o);
    else n_pass++;
  endtask

  task automatic test_fill();
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      n_total++; if (push_bqid_o !== 3'(i)) $display("FAIL fill_bqid: got %0d required %0d", push_bqid_o, i); else n_pass++;
      push(64'h100 + 64'(i), 8'(i), 1'b0, 64'h0);
    end
    n_total++; if (push_ready_o !== 1'b0) $display("FAIL fill_ready: got %b required 0", push_ready_o); else n_pass++;
    push(64'h999, 8'hff, 1'b0, 64'h0);
    n_total++; if (dut.count !== 4'd8) $display("FAIL fill_drop_count: got %0d required 8", dut.count); else n_pass++;
    n_total++; if (push_bqid_o !== 3'd0) $display("FAIL fill_drop_tail: got %0d required 0", push_bqid_o); else n_pass++;
  endtask

  task automatic test_wrap();
    repeat (3) commit();
    n_total++; if (dut.count !== 4'd5) $display("FAIL wrap_commit_count: got %0d required 5", dut.count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (push_bqid_o !== 3'(i)) $display("FAIL wrap_bqid: got %0d required %0d", push_bqid_o, i); else n_pass++;
      push(64'h200 + 64'(i), 8'(8 + i), 1'b0, 64'h0);
    end
    n_total++; if (push_ready_o !== 1'b0) $display("FAIL wrap_full: got %b required 0", push_ready_o); else n_pass++;
    push_valid_i = 1'b1;
    commit_valid_i = 1'b1;
    cycle();
    push_valid_i = 1'b0;
    commit_valid_i = 1'b0;
    n_total++; if (dut.count !== 4'd8) $display("FAIL full_pushcommit_count: got %0d required 8", dut.count); else n_pass++;
    n_total++; if (push_bqid_o !== 3'd4) $display("FAIL full_pushcommit_tail: got %0d required 4", push_bqid_o); else n_pass++;
  endtask

  task automatic test_mispredict();
    reset_dut();
    push(64'h1000, 8'h11, 1'b1, 64'h1040);
    sb.push_back('{id: 8'h11, bqid: 3'd0, pc: 64'h1080});
    resolve(3'd0, 1'b1, 64'h1080);
    n_total++; if (mispredict_valid_o !== 1'b1) $display("FAIL mp_target_valid: got %b required 1", mispredict_valid_o); else n_pass++;
    n_total++; if (head_resolved_o !== 1'b1) $display("FAIL mp_head_resolved: got %b required 1", head_resolved_o); else n_pass++;
    cycle();
    n_total++; if (mispredict_valid_o !== 1'b0) $display("FAIL mp_one_cycle: got %b required 0", mispredict_valid_o); else n_pass++;
    push(64'h2000, 8'h22, 1'b1, 64'h2040);
    sb.push_back('{id: 8'h22, bqid: 3'd1, pc: 64'h2004});
    resolve(3'd1, 1'b0, 64'h0);
    n_total++; if (mispredict_pc_o !== 64'h2004) $display("FAIL mp_nt_pc: got %h required 2004", mispredict_pc_o); else n_pass++;
    push(64'h2000, 8'h23, 1'b1, 64'h2040);
    resolve(3'd2, 1'b1, 64'h2040);
    n_total++; if (mispredict_valid_o !== 1'b0) $display("FAIL mp_correct_taken: got %b required 0", mispredict_valid_o); else n_pass++;
    push(64'h3000, 8'h24, 1'b0, 64'h3004);
    resolve(3'd3, 1'b0, 64'h0);
    n_total++; if (mispredict_valid_o !== 1'b0) $display("FAIL mp_correct_nt: got %b required 0", mispredict_valid_o); else n_pass++;
    push(64'hffff_ffff_ffff_fffc, 8'h25, 1'b1, 64'h40);
    sb.push_back('{id: 8'h25, bqid: 3'd4, pc: 64'h0});
    resolve(3'd4, 1'b0, 64'h0);
    n_total++; if (mispredict_pc_o !== 64'h0) $display("FAIL mp_pc_wrap: got %h required 0", mispredict_pc_o); else n_pass++;
    resolve(3'd6, 1'b1, 64'h9);
    n_total++; if (mispredict_valid_o !== 1'b0) $display("FAIL mp_invalid_entry: got %b required 0", mispredict_valid_o); else n_pass++;
    commit();
    n_total++; if (head_resolved_o !== 1'b1) $display("FAIL mp_next_head_resolved: got %b required 1", head_resolved_o); else n_pass++;
  endtask

  task automatic test_squash();
    reset_dut();
    for (int i = 0; i < 5; i++) push(64'h4000 + 64'(i * 16), 8'(8'h30 + i), 1'b0, 64'h0);
    squash(1'b1, 3'd2);
    n_total++; if (dut.count !== 4'd3) $display("FAIL squash_keep_count: got %0d required 3", dut.count); else n_pass++;
    n_total++; if (push_bqid_o !== 3'd3) $display("FAIL squash_keep_tail: got %0d required 3", push_bqid_o); else n_pass++;
    squash(1'b0, 3'd0);
    n_total++; if (dut.count !== 4'd0) $display("FAIL squash_all_count: got %0d required 0", dut.count); else n_pass++;
    n_total++; if (head_valid_o !== 1'b0) $display("FAIL squash_all_head: got %b required 0", head_valid_o); else n_pass++;
  endtask

  task automatic test_squash_resolve();
    reset_dut();
    for (int i = 0; i < 5; i++) push(64'h5000 + 64'(i * 16), 8'(8'h40 + i), 1'b0, 64'h0);
    squash_valid_i = 1'b1; squash_keep_i = 1'b1; squash_bqid_i = 3'd1;
    resolve_valid_i = 1'b1; resolve_bqid_i = 3'd3; resolve_taken_i = 1'b1; resolve_target_i = 64'h7000;
    push_valid_i = 1'b1; push_id_i = 8'h4f;
    cycle();
    squash_valid_i = 1'b0; resolve_valid_i = 1'b0; push_valid_i = 1'b0;
    n_total++; if (dut.count !== 4'd2) $display("FAIL sqres_count: got %0d required 2", dut.count); else n_pass++;
    n_total++; if (push_bqid_o !== 3'd2) $display("FAIL sqres_push_dropped: got %0d required 2", push_bqid_o); else n_pass++;
    n_total++; if (mispredict_valid_o !== 1'b0) $display("FAIL sqres_killed: got %b required 0", mispredict_valid_o); else n_pass++;
    squash_valid_i = 1'b1; squash_keep_i = 1'b0;
    resolve_valid_i = 1'b1; resolve_bqid_i = 3'd0;
    cycle();
    squash_valid_i = 1'b0; resolve_valid_i = 1'b0;
    n_total++; if (mispredict_valid_o !== 1'b0) $display("FAIL sqall_killed: got %b required 0", mispredict_valid_o); else n_pass++;
    for (int i = 0; i < 3; i++) push(64'h6000 + 64'(i * 16), 8'(8'h50 + i), 1'b0, 64'h0);
    sb.push_back('{id: 8'h51, bqid: 3'd1, pc: 64'h7777});
    squash_valid_i = 1'b1; squash_keep_i = 1'b1; squash_bqid_i = 3'd1;
    resolve_valid_i = 1'b1; resolve_bqid_i = 3'd1; resolve_taken_i = 1'b1; resolve_target_i = 64'h7777;
    commit_valid_i = 1'b1;
    cycle();
    squash_valid_i = 1'b0; resolve_valid_i = 1'b0; commit_valid_i = 1'b0;
    n_total++; if (mispredict_valid_o !== 1'b1) $display("FAIL sqkeep_mp: got %b required 1", mispredict_valid_o); else n_pass++;
    n_total++; if (dut.count !== 4'd1) $display("FAIL sq_commit_count: got %0d required 1", dut.count); else n_pass++;
    n_total++; if (head_resolved_o !== 1'b1) $display("FAIL sq_commit_head_res: got %b required 1", head_resolved_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    push(64'h10, 8'h01, 1'b0, 64'h0);
    push_valid_i = 1'b1;
    commit_valid_i = 1'b1;
    cycle();
    push_valid_i = 1'b0;
    commit_valid_i = 1'b0;
    n_total++; if (dut.count !== 4'd1) $display("FAIL b2b_count: got %0d required 1", dut.count); else n_pass++;
    n_total++; if (push_bqid_o !== 3'd2) $display("FAIL b2b_tail: got %0d required 2", push_bqid_o); else n_pass++;
    commit();
    commit();
    n_total++; if (dut.count !== 4'd0) $display("FAIL empty_commit_count: got %0d required 0", dut.count); else n_pass++;
    n_total++; if (push_bqid_o !== 3'd2) $display("FAIL empty_commit_tail: got %0d required 2", push_bqid_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int i = 0; i < 4; i++) push(64'h8000 + 64'(i * 16), 8'(8'h60 + i), 1'b0, 64'h0);
    rst = 1'b1;
    resolve(3'd2, 1'b1, 64'h9000);
    rst = 1'b0;
    n_total++; if (mispredict_valid_o !== 1'b0) $display("FAIL rstres_mp: got %b required 0", mispredict_valid_o); else n_pass++;
    n_total++; if (dut.count !== 4'd0) $display("FAIL rstres_count: got %0d required 0", dut.count); else n_pass++;
    for (int i = 0; i < 4; i++) push(64'h8000 + 64'(i * 16), 8'(8'h60 + i), 1'b0, 64'h0);
    sb.push_back('{id: 8'h62, bqid: 3'd2, pc: 64'h9000});
    resolve(3'd2, 1'b1, 64'h9000);
    reset_dut();
    n_total++; if (mispredict_valid_o !== 1'b0) $display("FAIL rstmid_mp: got %b required 0", mispredict_valid_o); else n_pass++;
    n_total++; if (dut.count !== 4'd0) $display("FAIL rstmid_count: got %0d required 0", dut.count); else n_pass++;
    n_total++; if (head_valid_o !== 1'b0) $display("FAIL rstmid_head: got %b required 0", head_valid_o); else n_pass++;
    n_total++; if (mispredict_pc_o !== 64'h0) $display("FAIL rstmid_pc: got %h required 0", mispredict_pc_o); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    push_valid_i = 1'b0; push_pc_i = '0; push_id_i = '0; push_bp_taken_i = 1'b0; push_bp_pcnext_i = '0;
    resolve_valid_i = 1'b0; resolve_bqid_i = '0; resolve_taken_i = 1'b0; resolve_target_i = '0;
    commit_valid_i = 1'b0; squash_valid_i = 1'b0; squash_keep_i = 1'b0; squash_bqid_i = '0;
    cycle();
    cycle();
    rst = 1'b0;
    test_reset();
    test_fill();
    test_wrap();
    test_mispredict();
    test_squash();
    test_squash_resolve();
    test_back_to_back();
    test_reset_mid();
    cycle();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/branch_queue.md
BRANCH_QUEUE -- requirements
Module: branch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of 2, >=2).
REQ-002 SHALL have parameter ID_W, default 8, instruction id width; BQID_W = log2(DEPTH); PC width fixed at 64.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 push_valid_i  in  1  decode pushes one branch this cycle.
REQ-006 push_ready_o  out  1  queue not full.
REQ-007 push_pc_i  in  64  branch pc.
REQ-008 push_id_i  in  ID_W  instruction id.
REQ-009 push_bp_taken_i / push_bp_pcnext_i  in  1 / 64  fetch prediction.
REQ-010 push_bqid_o  out  BQID_W  slot allocated to the push (equals tail pointer), combinational.
REQ-011 resolve_valid_i, resolve_bqid_i, resolve_taken_i, resolve_target_i  in  1, BQID_W, 1, 64  branch unit outcome.
REQ-012 mispredict_valid_o, mispredict_id_o, mispredict_bqid_o, mispredict_pc_o  out  1, ID_W, BQID_W, 64  registered redirect request.
REQ-013 commit_valid_i  in  1  retire head entry; head_valid_o, head_resolved_o  out  1, 1  head status.
REQ-014 squash_valid_i, squash_keep_i, squash_bqid_i  in  1, 1, BQID_W  flush request.

Function
REQ-015 SHALL be a circular FIFO: head/tail pointers BQID_W bits wrapping modulo DEPTH, plus count 0..DEPTH.
REQ-016 Entry fields: valid, resolved, pc, id, bp_taken, bp_pcnext.
REQ-017 push_ready_o SHALL be (count != DEPTH); push accepted iff push_valid_i && push_ready_o; accepted push writes tail with resolved=0, tail+1.
REQ-018 Push while full SHALL be dropped; no state change.
REQ-019 Accepted commit (commit_valid_i && count != 0) SHALL clear head valid, head+1; commit on empty ignored.
REQ-020 Push and commit same cycle SHALL leave count unchanged; both pointers advance; works when full and when count==1.
REQ-021 Resolve to valid entry SHALL set resolved=1; resolve to invalid entry ignored.
REQ-022 Mispredict when resolve_taken_i != bp_taken, or both taken and resolve_target_i != bp_pcnext.
REQ-023 Mispredict outputs SHALL be registered: asserted exactly one cycle after resolve, for one cycle; pc = resolve_target_i if taken else entry pc + 4 (64-bit wrap).
REQ-024 Correct resolve SHALL not raise mispredict_valid_o.
REQ-025 Squash with squash_keep_i=1: tail <= squash_bqid_i+1, entries strictly younger invalidated, count recomputed; squash_bqid_i itself retained.
REQ-026 Squash with squash_keep_i=0: all entries invalidated, tail <= head, count <= 0.
REQ-027 Squash SHALL take priority over push same cycle (push dropped); commit same cycle still applies to head.
REQ-028 Resolve same cycle as squash to a squashed entry SHALL raise no mispredict.
REQ-029 head_valid_o = (count != 0); head_resolved_o = head entry resolved && head_valid_o.
REQ-030 Commit of unresolved head is a protocol error; queue still pops.

Reset
REQ-031 While rst=1 at clk edge: head=tail=0, count=0, all valid/resolved=0, mispredict_valid_o=0, mispredict_id/bqid/pc=0.
REQ-032 After reset: push_ready_o=1, push_bqid_o=0, head_valid_o=0, head_resolved_o=0.
REQ-033 rst asserted mid-operation SHALL discard all entries and any pending mispredict next cycle.

Verification
REQ-034 DEPTH=8: 8 pushes, no commit -> push_bqid_o 0..7, push_ready_o=0 after 8th; 9th push dropped, count stays 8.
REQ-035 Push pc=0x1000 bp_taken=1 pcnext=0x1040; resolve taken=1 target=0x1080 -> next cycle mispredict_valid_o=1, pc=0x1080 for one cycle.
REQ-036 Push pc=0x2000 bp_taken=1; resolve taken=0 -> mispredict pc=0x2004; repeat with correct outcome -> no mispredict.
REQ-037 5 pushes (bqid 0..4), squash keep=1 bqid=2 -> count=3, push_bqid_o=3; then keep=0 -> count=0, head_valid_o=0.
REQ-038 Wrap: push 8, commit 3, push 3 -> push_bqid_o 0,1,2; simultaneous push+commit while full keeps count=8.
REQ-039 rst pulse with 4 entries and a resolve in flight -> count=0, no mispredict_valid_o following.
